// File: rtl/logic_pkg.sv
// logic_pkg
//   Shared definitions for the logic-unit issue path and the ALU decoder:
//   R-type funct codes for the four logic instructions, the logic unit's
//   2-bit op encoding, and the layout of one buffered issue entry.
//   No ports (package).
package logic_pkg;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_AND = 2'b01,
    OP_OR  = 2'b10,
    OP_XOR = 2'b11
  } lop_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    lop_e        op;
    logic        err;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

  // Illegal functs still produce an entry so they retire in order; the op is
  // forced to NOR only so the unit sees a defined code, its result is ignored.
  function automatic entry_t decode_entry(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [5:0]  funct);
    entry_t e;
    e.a   = a;
    e.b   = b;
    e.op  = OP_NOR;
    e.err = 1'b0;
    case (funct)
      FUNCT_AND: e.op = OP_AND;
      FUNCT_OR:  e.op = OP_OR;
      FUNCT_XOR: e.op = OP_XOR;
      FUNCT_NOR: e.op = OP_NOR;
      default:   e.err = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/logic_op_fifo.sv
// logic_op_fifo
//   Generic synchronous FIFO with registered storage. The head word is read
//   straight out of the storage array, so rdata never depends on wdata.
//   Ports:
//     clk, rst        rising-edge clock, async active-high reset
//     push, wdata     write request / data (ignored when full)
//     pop             read request (ignored when empty)
//     rdata           head entry (undefined content when empty)
//     full, empty     occupancy flags
module logic_op_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH[PTR_W:0]);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) bits, so +1 wraps modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through rdata while non-empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/logic_op_issue.sv
// logic_op_issue
//   Issue stage in front of the 32-bit logic unit. Decodes funct on entry,
//   buffers {a, b, op, err} in a FIFO, drives the unit from the FIFO head and
//   captures the unit's combinational result into a registered output.
//   Ports:
//     clk, rst                     clock, async active-high reset
//     in_valid/in_ready            instruction handshake (in_ready = not full)
//     in_a, in_b, in_funct         operands and R-type funct
//     lu_a, lu_b, lu_op            to the logic unit (zero when FIFO empty)
//     lu_out                       combinational result from the logic unit
//     res_valid/res_ready          result handshake
//     res_data, res_zero, res_err  registered result and flags
//     err_count                    saturating count of retired illegal functs
module logic_op_issue
  import logic_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ERRW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_a,
  input  logic [31:0]     in_b,
  input  logic [5:0]      in_funct,
  output logic [31:0]     lu_a,
  output logic [31:0]     lu_b,
  output logic [1:0]      lu_op,
  input  logic [31:0]     lu_out,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [31:0]     res_data,
  output logic            res_zero,
  output logic            res_err,
  output logic [ERRW-1:0] err_count
);

  entry_t               push_entry;
  entry_t               head;
  logic [ENTRY_W-1:0]   head_raw;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 head_valid;
  logic                 retire;

  assign push_entry = decode_entry(in_a, in_b, in_funct);

  // in_ready only looks at full, never at a same-cycle pop, which keeps
  // res_ready out of the input-side timing path.
  assign in_ready = !fifo_full;

  logic_op_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid),
    .wdata (push_entry),
    .pop   (retire),
    .rdata (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head       = entry_t'(head_raw);
  assign head_valid = !fifo_empty;

  assign lu_a  = head_valid ? head.a : 32'd0;
  assign lu_b  = head_valid ? head.b : 32'd0;
  assign lu_op = head_valid ? head.op : OP_NOR;

  assign retire = head_valid && (!res_valid || res_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_zero  <= 1'b0;
      res_err   <= 1'b0;
      err_count <= '0;
    end else if (retire) begin
      res_valid <= 1'b1;
      if (head.err) begin
        res_data <= '0;
        res_zero <= 1'b0;
        res_err  <= 1'b1;
        if (err_count != '1) err_count <= err_count + 1'b1;
      end else begin
        res_data <= lu_out;
        res_zero <= (lu_out == 32'd0);
        res_err  <= 1'b0;
      end
    end else if (res_valid && res_ready) begin
      // Data and flags intentionally hold their last values.
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_logic_op_issue.sv
module tb_logic_op_issue;
  import logic_pkg::*;

  localparam int DEPTH   = 4;
  localparam int ERRW    = 2;
  localparam int ERR_MAX = (1 << ERRW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_a;
  logic [31:0]     in_b;
  logic [5:0]      in_funct;
  logic [31:0]     lu_a;
  logic [31:0]     lu_b;
  logic [1:0]      lu_op;
  logic [31:0]     lu_out;
  logic            res_valid;
  logic            res_ready;
  logic [31:0]     res_data;
  logic            res_zero;
  logic            res_err;
  logic [ERRW-1:0] err_count;

  always #5 clk = ~clk;

  logic_op_issue #(.DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_funct  (in_funct),
    .lu_a      (lu_a),
    .lu_b      (lu_b),
    .lu_op     (lu_op),
    .lu_out    (lu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_zero  (res_zero),
    .res_err   (res_err),
    .err_count (err_count)
  );

  // Stand-in for the parent's logic unit.
  always_comb begin
    lu_out = 32'd0;
    case (lu_op)
      2'b00: lu_out = ~(lu_a | lu_b);
      2'b01: lu_out = lu_a & lu_b;
      2'b10: lu_out = lu_a | lu_b;
      2'b11: lu_out = lu_a ^ lu_b;
      default: lu_out = 32'd0;
    endcase
  end

  typedef struct {
    logic [31:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks   = 0;
  int   n_pass     = 0;
  int   model_errs = 0;
  bit   rand_en    = 1'b0;
  exp_t mon_e;

  function automatic exp_t ref_model(input logic [31:0] a, input logic [31:0] b,
                                     input logic [5:0] f);
    exp_t e;
    e.err = 1'b0;
    case (f)
      6'h24:   e.data = a & b;
      6'h25:   e.data = a | b;
      6'h26:   e.data = a ^ b;
      6'h27:   e.data = ~(a | b);
      default: begin e.data = 32'd0; e.err = 1'b1; end
    endcase
    e.zero = !e.err && (e.data == 32'd0);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every transferred result is compared with the oldest
  // expectation.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_result: got res_data 0x%08h err %0d, expected no result",
                 res_data, res_err);
      end else begin
        mon_e = sb.pop_front();
        check("res_data", res_data, mon_e.data);
        check("res_zero", {31'd0, res_zero}, {31'd0, mon_e.zero});
        check("res_err", {31'd0, res_err}, {31'd0, mon_e.err});
        if (mon_e.err && model_errs < ERR_MAX) model_errs++;
        check("err_count", {{(32-ERRW){1'b0}}, err_count}, model_errs);
      end
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_en) res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_funct = f;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(ref_model(a, b, f));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready stuck low, expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0 && !res_valid) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (!ok) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d results outstanding, expected 0", sb.size());
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_funct  = '0;
    res_ready = 1'b1;
    #12;
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_lu_a", lu_a, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_err_count", {{(32-ERRW){1'b0}}, err_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Single AND: head drives the unit after the push edge, result one edge later.
    send(32'hF0F0_0000, 32'hFF00_FF00, 6'h24);
    check("and_lu_op", {30'd0, lu_op}, 32'd1);
    check("and_lu_a", lu_a, 32'hF0F0_0000);
    check("and_lu_b", lu_b, 32'hFF00_FF00);
    check("no_bypass", {31'd0, res_valid}, 32'd0);
    @(posedge clk);
    #1;
    check("and_res_valid", {31'd0, res_valid}, 32'd1);
    check("and_res_data", res_data, 32'hF000_0000);
    drain();

    // NOR producing zero.
    send(32'hFFFF_FFFF, 32'h0, 6'h27);
    @(posedge clk);
    #1;
    check("nor_res_data", res_data, 32'd0);
    check("nor_res_zero", {31'd0, res_zero}, 32'd1);
    drain();

    // Back-pressure: result register plus DEPTH FIFO entries.
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++)
      send(32'h1111_0000 + i, 32'h0F0F_0F0F, 6'h25);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_res_valid_hold", {31'd0, res_valid}, 32'd1);
    check("bp_res_data_hold", res_data, 32'h1F1F_0F0F);
    check("bp_in_ready_still_low", {31'd0, in_ready}, 32'd0);
    res_ready = 1'b1;
    repeat (DEPTH + 1) @(negedge clk);
    #1;
    check("bp_one_per_cycle", sb.size(), 32'd0);
    drain();

    // Illegal funct between two XORs.
    send(32'h1234_5678, 32'hFFFF_0000, 6'h26);
    send(32'hDEAD_BEEF, 32'h1, 6'h20);
    send(32'hAAAA_AAAA, 32'hAAAA_AAAA, 6'h26);
    drain();
    check("illegal_err_count", {{(32-ERRW){1'b0}}, err_count}, 32'd1);

    // Saturation of the narrow counter.
    send(32'h1, 32'h2, 6'h00);
    send(32'h3, 32'h4, 6'h20);
    send(32'h5, 32'h6, 6'h2A);
    send(32'h7, 32'h8, 6'h3F);
    send(32'h9, 32'hA, 6'h23);
    drain();
    check("sat_err_count", {{(32-ERRW){1'b0}}, err_count}, ERR_MAX);

    // Async reset mid-cycle with entries queued.
    res_ready = 1'b0;
    send(32'h8000_0001, 32'h0, 6'h25);
    send(32'h2, 32'h3, 6'h24);
    send(32'h4, 32'h5, 6'h26);
    send(32'h6, 32'h7, 6'h20);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("pre_rst_res_valid", {31'd0, res_valid}, 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_res_valid", {31'd0, res_valid}, 32'd0);
    check("arst_res_data", res_data, 32'd0);
    check("arst_lu_a", lu_a, 32'd0);
    check("arst_lu_b", lu_b, 32'd0);
    check("arst_lu_op", {30'd0, lu_op}, 32'd0);
    check("arst_err_count", {{(32-ERRW){1'b0}}, err_count}, 32'd0);
    sb.delete();
    model_errs = 0;
    @(negedge clk);
    rst       = 1'b0;
    res_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_no_stale", {31'd0, res_valid}, 32'd0);

    // Randomized traffic with random back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 300; i++) begin
      int gap;
      int sel;
      logic [5:0] f;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      sel = $urandom_range(0, 4);
      f = (sel < 4) ? 6'(6'h24 + sel) : 6'($urandom);
      if ($urandom_range(0, 7) == 0) send($urandom, ~32'($urandom), f);
      else send($urandom, $urandom, f);
    end
    rand_en = 1'b0;
    @(posedge clk);
    #1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/logic_op_issue.md
# logic_op_issue

Issue stage directly upstream of the 32-bit logic unit (nor/and/or/xor, `op` 2-bit, `a`/`b`/`out` 32-bit). It accepts R-type logic instructions (operands plus 6-bit funct) over a valid/ready handshake and buffers them in a small FIFO. It decodes funct to the logic unit's 2-bit op, drives the unit's inputs from the FIFO head, and captures the unit's combinational result into a registered output with zero and error flags.

## Interface
- DEPTH, 4, FIFO entries; power of 2, ≥2
- ERRW, 16, width of saturating illegal-funct counter
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept (not full)
- in_a  in  32  operand rs
- in_b  in  32  operand rt
- in_funct  in  6  funct field
- lu_a  out  32  to logic unit `a`
- lu_b  out  32  to logic unit `b`
- lu_op  out  2  to logic unit `op`
- lu_out  in  32  from logic unit `out` (combinational)
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer takes result
- res_data  out  32  result
- res_zero  out  1  res_data == 0 (legal ops only)
- res_err  out  1  entry had illegal funct
- err_count  out  ERRW  illegal functs retired, saturating

## Operation
- Decode at push: funct 0x24 and→op 01, 0x25 or→10, 0x26 xor→11, 0x27 nor→00; any other funct → illegal, op 00, err bit set. Entry = {a, b, op, err} stored in FIFO.
- Head drive: FIFO non-empty → lu_a/lu_b/lu_op = head fields; empty → all zero. Driven from storage registers, no combinational path from in_* to lu_*.
- Retire: head valid and (!res_valid or res_ready) → load result register, pop head. Legal: res_data = lu_out, res_zero = (lu_out == 0), res_err = 0. Illegal: res_data = 0, res_zero = 0, res_err = 1, err_count += 1 unless at all-ones.
- Result consumed (res_valid & res_ready) with no new retire → res_valid = 0; data/flags hold last values.
- in_ready = !full; a push is not accepted on the strength of a same-cycle pop, so no full-path combinational dependence on res_ready.
- Push and pop in the same cycle when neither full nor empty: both happen, occupancy unchanged.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- Reset, async and valid mid-operation: FIFO emptied (pointers/count 0), lu_* = 0, res_valid = 0, res_data = 0, res_zero = 0, res_err = 0, err_count = 0, in_ready = 1 after deassert. In-flight entries are discarded.

## Timing
- Push at edge N → entry is head at N (if FIFO was empty) → lu_* valid after N → retire at edge N+1 → res_valid high after N+1. Min latency 1 cycle handshake-to-result.
- Throughput: 1 op/cycle with res_ready held high.
- res_ready low: result holds stable; FIFO fills, in_ready drops after DEPTH pushes (DEPTH+1 ops absorbed including the result register).
- Empty FIFO and in_valid: no bypass; res_valid never rises the same cycle as the push.

## Structure
- Package `logic_pkg`: funct constants (FUNCT_AND/OR/XOR/NOR), op encodings (OP_NOR=00, OP_AND=01, OP_OR=10, OP_XOR=11), entry struct/width constant. It is shared with the ALU decoder.
- One sub-module `logic_op_fifo` (generic synchronous FIFO, parameter WIDTH/DEPTH, full/empty, async active-high reset). Decode, retire and the counter live in the top.
- The logic unit is instantiated by the parent, not inside this block.

## Test plan
- Single and: a=0xF0F0_0000, b=0xFF00_FF00, funct 0x24 → lu_op=01 one edge after push; next edge res_data=0xF000_0000, zero=0, err=0.
- Nor zero: a=0xFFFF_FFFF, b=0, funct 0x27 → res_data=0, res_zero=1.
- Back-pressure: res_ready=0, push 5 ops, DEPTH=4 → in_ready low after 5th accept. Release → results retire in order, one per cycle.
- Illegal funct 0x20 between two xor ops → middle result err=1, data=0, err_count=1. Neighbours are correct and in order.
- Saturation: ERRW=2, 5 illegal ops → err_count stops at 3.
- Async reset asserted between edges with 3 queued → outputs zero immediately, in_ready=1 after release, no stale result appears.
